// File: rtl/psram_frame_writer.sv
// psram_frame_writer
//   Write-side frame buffer between the camera capture stage and the PSRAM controller.
//   Captured pixels are queued in an internal FIFO and sent out as fixed-length burst writes
//   to linear frame addresses. The last burst of a frame is shortened so that it ends on the
//   frame boundary. A camera frame start realigns the write pointer to address 0.
//
// Ports
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   frame_start                 vsync pulse; requests a resync (flush + address 0)
//   pix_valid, pix_data         incoming pixel stream
//   mem_wr_req/addr/len         burst request, held until mem_wr_ack
//   mem_wr_ack                  controller accepts the request
//   mem_wr_data_req             controller pulls one word
//   mem_wr_data                 word returned one cycle after mem_wr_data_req
//   mem_wr_done                 controller reports the burst committed
//   frame_done                  one-cycle pulse when the last burst of a frame completes
//   pix_overflow                sticky pixel-drop flag, cleared by a resync
//   fifo_level                  current FIFO occupancy
module psram_frame_writer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FIFO_AW     = 10,
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = 307200
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [DATA_W-1:0]  pix_data,
    output logic               mem_wr_req,
    output logic [ADDR_W-1:0]  mem_wr_addr,
    output logic [7:0]         mem_wr_len,
    input  logic               mem_wr_ack,
    input  logic               mem_wr_data_req,
    output logic [DATA_W-1:0]  mem_wr_data,
    input  logic               mem_wr_done,
    output logic               frame_done,
    output logic               pix_overflow,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int unsigned Depth = 2 ** FIFO_AW;

    typedef enum logic [1:0] {StIdle, StReq, StData, StWait} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0]  mem_q [Depth];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   level_q;
    logic [DATA_W-1:0]  data_q;
    logic               overflow_q;
    logic               resync_q;

    logic [31:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         dcnt_q, dcnt_d;
    logic               frame_done_q, frame_done_d;

    logic [31:0]        rem;
    logic [31:0]        wcnt_next;
    logic [7:0]         blen;
    logic               full;
    logic               flush;
    logic               push;
    logic               pop;

    assign rem  = FRAME_WORDS - wcnt_q;
    assign blen = (rem >= BURST_LEN) ? 8'(BURST_LEN) : rem[7:0];
    assign full = (level_q == (FIFO_AW + 1)'(Depth));

    // A pending resync is only acted on between bursts, so a burst in flight always finishes.
    assign flush = (state_q == StIdle) && resync_q;
    assign push  = pix_valid && !full && !flush;
    // dcnt_q == 0 once the burst is fully drained: extra data requests are ignored.
    assign pop   = (state_q == StData) && mem_wr_data_req && (dcnt_q != 8'd0);

    assign wcnt_next = wcnt_q + 32'(len_q);

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        addr_d       = addr_q;
        len_d        = len_q;
        dcnt_d       = dcnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (resync_q) begin
                    wcnt_d = '0;
                end else if (32'(level_q) >= 32'(blen)) begin
                    addr_d  = ADDR_W'(BASE_ADDR + wcnt_q);
                    len_d   = blen;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_wr_ack) begin
                    dcnt_d  = len_q;
                    state_d = StData;
                end
            end
            StData: begin
                if (pop) begin
                    dcnt_d = dcnt_q - 8'd1;
                    if (dcnt_q == 8'd1) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (mem_wr_done) begin
                    state_d = StIdle;
                    if (wcnt_next == FRAME_WORDS) begin
                        wcnt_d       = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            wcnt_q       <= '0;
            addr_q       <= ADDR_W'(BASE_ADDR);
            len_q        <= '0;
            dcnt_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            dcnt_q       <= dcnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // FIFO storage: no reset, contents are only meaningful below level_q.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wptr_q] <= pix_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            data_q <= '0;
        end else if (pop) begin
            data_q <= mem_q[rptr_q];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            overflow_q <= 1'b0;
        end else if (pix_valid && full) begin
            overflow_q <= 1'b1;
        end
    end

    // A frame_start coinciding with the flush is absorbed into that flush.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            resync_q <= 1'b0;
        end else if (frame_start) begin
            resync_q <= 1'b1;
        end
    end

    assign mem_wr_req   = (state_q == StReq);
    assign mem_wr_addr  = addr_q;
    assign mem_wr_len   = len_q;
    assign mem_wr_data  = data_q;
    assign frame_done   = frame_done_q;
    assign pix_overflow = overflow_q;
    assign fifo_level   = level_q;

endmodule
